// File: rtl/osc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | osc_pkg: shared sweep state encoding and default voice geometry. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package osc_pkg;

  localparam int C_N_DEF  = 24;
  localparam int C_CW_DEF = 20;
  localparam int C_VW_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/osc_voice_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | osc_voice_mux: selects one voice's fields from the packed arrays;|
// | any index outside 0..N-1 (the idle sentinel N) yields zeros.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module osc_voice_mux
  import osc_pkg::*;
#(
  parameter int N  = C_N_DEF,
  parameter int CW = C_CW_DEF,
  parameter int VW = C_VW_DEF,
  parameter int IW = $clog2(N + 1)
) (
  input  logic [IW-1:0]   i_idx,
  input  logic [N*CW-1:0] i_count,
  input  logic [N*CW-1:0] i_max,
  input  logic [N*VW-1:0] i_velocity,
  input  logic [N-1:0]    i_ended_note,
  input  logic [N-1:0]    i_key_pressed,
  output logic [CW-1:0]   o_count,
  output logic [CW-1:0]   o_max,
  output logic [VW-1:0]   o_velocity,
  output logic            o_ended_note,
  output logic            o_key_pressed
);

  always_comb begin
    o_count       = '0;
    o_max         = '0;
    o_velocity    = '0;
    o_ended_note  = 1'b0;
    o_key_pressed = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_idx == IW'(i)) begin
        o_count       = i_count[i*CW +: CW];
        o_max         = i_max[i*CW +: CW];
        o_velocity    = i_velocity[i*VW +: VW];
        o_ended_note  = i_ended_note[i];
        o_key_pressed = i_key_pressed[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/osc_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | osc_scan: per-tick voice sweep with handshake, plus new-note     |
// | allocation to the lowest free voice at the end of each sweep.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module osc_scan
  import osc_pkg::*;
#(
  parameter  int N  = C_N_DEF,
  parameter  int CW = C_CW_DEF,
  parameter  int VW = C_VW_DEF,
  localparam int IW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_tick,
  input  logic [N*CW-1:0] count,
  input  logic [N*CW-1:0] max,
  input  logic [N*VW-1:0] current_velocity,
  input  logic [N-1:0]    ended_note,
  input  logic [N-1:0]    key_pressed,
  input  logic            note_on_req,
  input  logic [VW-1:0]   note_on_velocity,
  input  logic            out_ready,
  output logic [IW-1:0]   osc_num,
  output logic [CW-1:0]   count_sel,
  output logic [CW-1:0]   max_sel,
  output logic [VW-1:0]   velocity_sel,
  output logic            ended_note_sel,
  output logic            key_pressed_sel,
  output logic            sel_valid,
  output logic            busy,
  output logic            sweep_done,
  output logic            overrun,
  output logic            alloc_fail,
  output logic [N-1:0]    new_note_we,
  output logic [N*VW-1:0] new_note_velocity
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic [IW-1:0] w_mux_idx;
  logic          w_load;
  logic          w_start;
  logic          w_accept;
  logic          w_last;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_max;
  logic [VW-1:0] w_velocity;
  logic          w_ended;
  logic          w_key;

  logic [CW-1:0] r_count_sel;
  logic [CW-1:0] r_max_sel;
  logic [VW-1:0] r_velocity_sel;
  logic          r_ended_sel;
  logic          r_key_sel;

  logic          r_pend;
  logic [VW-1:0] r_pend_vel;
  logic          r_found;
  logic [IW-1:0] r_free_idx;
  logic          r_overrun;
  logic          w_alloc;

  assign w_start  = (r_state == IDLE) && sample_tick;
  assign w_accept = (r_state == SCAN) && out_ready;
  assign w_last   = (r_idx == IW'(N - 1));

  // The mux is pointed at the voice to present next, so the field
  // registers only load on sweep start or acceptance and hold otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_mux_idx   = IW'(N);
    case (r_state)
      IDLE: begin
        if (sample_tick) begin
          w_state_nxt = SCAN;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
          w_mux_idx   = '0;
        end
      end
      SCAN: begin
        if (out_ready) begin
          w_load = 1'b1;
          if (w_last) begin
            w_state_nxt = DONE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
            w_mux_idx = r_idx + IW'(1);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  osc_voice_mux #(
    .N  (N),
    .CW (CW),
    .VW (VW),
    .IW (IW)
  ) u_mux (
    .i_idx         (w_mux_idx),
    .i_count       (count),
    .i_max         (max),
    .i_velocity    (current_velocity),
    .i_ended_note  (ended_note),
    .i_key_pressed (key_pressed),
    .o_count       (w_count),
    .o_max         (w_max),
    .o_velocity    (w_velocity),
    .o_ended_note  (w_ended),
    .o_key_pressed (w_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count_sel    <= '0;
      r_max_sel      <= '0;
      r_velocity_sel <= '0;
      r_ended_sel    <= 1'b0;
      r_key_sel      <= 1'b0;
    end else if (w_load) begin
      r_count_sel    <= w_count;
      r_max_sel      <= w_max;
      r_velocity_sel <= w_velocity;
      r_ended_sel    <= w_ended;
      r_key_sel      <= w_key;
    end
  end

  // A request landing in DONE wins over the clear and waits for the next sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_vel <= '0;
    end else if (note_on_req) begin
      r_pend     <= 1'b1;
      r_pend_vel <= note_on_velocity;
    end else if (r_state == DONE) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_found    <= 1'b0;
      r_free_idx <= '0;
    end else if (w_start) begin
      r_found    <= 1'b0;
      r_free_idx <= '0;
    end else if (w_accept && !r_found && r_ended_sel && !r_key_sel) begin
      r_found    <= 1'b1;
      r_free_idx <= r_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= sample_tick && (r_state != IDLE);
    end
  end

  assign w_alloc = (r_state == DONE) && r_pend;

  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      assign new_note_we[g] = w_alloc && r_found && (r_free_idx == IW'(g));
      assign new_note_velocity[g*VW +: VW] = new_note_we[g] ? r_pend_vel : '0;
    end
  endgenerate

  assign osc_num         = (r_state == SCAN) ? r_idx : IW'(N);
  assign sel_valid       = (r_state == SCAN);
  assign busy            = (r_state != IDLE);
  assign sweep_done      = (r_state == DONE);
  assign overrun         = r_overrun;
  assign alloc_fail      = w_alloc && !r_found;
  assign count_sel       = r_count_sel;
  assign max_sel         = r_max_sel;
  assign velocity_sel    = r_velocity_sel;
  assign ended_note_sel  = r_ended_sel;
  assign key_pressed_sel = r_key_sel;

endmodule
`default_nettype wire
